// File: rtl/imm_encoder.sv
// Streaming immediate encoder: packs a 32-bit value into instruction bits [31:7] for
// the I/S/B/J/U formats, flags unrepresentable values and counts errors (saturating).
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    input  logic [2:0]       in_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      out_imm,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clear
);

    localparam logic [2:0] SRC_I = 3'd0;
    localparam logic [2:0] SRC_S = 3'd1;
    localparam logic [2:0] SRC_B = 3'd2;
    localparam logic [2:0] SRC_J = 3'd3;
    localparam logic [2:0] SRC_U = 3'd4;

    logic [24:0] enc_raw;
    logic [24:0] enc_imm;
    logic        enc_fits;
    logic        enc_err;
    logic        accept;
    logic        cnt_sat;

    // Field layout mirrors the decode-stage sign extender so the round trip is exact.
    always_comb begin
        enc_raw  = '0;
        enc_fits = 1'b0;
        case (in_src)
            SRC_I: begin
                enc_raw  = {in_value[11:0], 13'b0};
                enc_fits = (&in_value[31:11]) || !(|in_value[31:11]);
            end
            SRC_S: begin
                enc_raw  = {in_value[11:5], 13'b0, in_value[4:0]};
                enc_fits = (&in_value[31:11]) || !(|in_value[31:11]);
            end
            SRC_B: begin
                enc_raw  = {in_value[12], in_value[10:5], 13'b0, in_value[4:1], in_value[11]};
                enc_fits = ((&in_value[31:12]) || !(|in_value[31:12])) && !in_value[0];
            end
            SRC_J: begin
                enc_raw  = {in_value[20], in_value[10:1], in_value[11], in_value[19:12], 5'b0};
                enc_fits = ((&in_value[31:20]) || !(|in_value[31:20])) && !in_value[0];
            end
            SRC_U: begin
                enc_raw  = {in_value[31:12], 5'b0};
                enc_fits = !(|in_value[11:0]);
            end
            default: begin
                enc_raw  = '0;
                enc_fits = 1'b0;
            end
        endcase
    end

    assign enc_err  = !enc_fits;
    assign enc_imm  = enc_err ? 25'h0 : enc_raw;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_sat  = &err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_imm   <= enc_imm;
            out_err   <= enc_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear wins over a same-cycle erroring beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clear) begin
            err_count <= '0;
        end else if (accept && enc_err && !cnt_sat) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
